// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between the instruction-fetch (I) and load/store (D)
// ports, drives the memory strobes and aborts accesses that never see mem_ready.
module mem_bus_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int TIMEOUT       = 16,
  parameter int DATA_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  // Handshake: a requester holds req (and its addr/we/wdata) high until it sees its
  // one-cycle done pulse; the request is captured at grant, so later input changes
  // are ignored. On the memory side a strobe stays high until mem_ready ends ACCESS.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int   TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_q, last_grant_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TW-1:0]     tmo_cnt;
  logic              err_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic              grant, winner, finish_ok, finish_tmo, tmo_hit;
  logic [DATA_W-1:0] resp_data;

  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    winner     = PORT_I;
    finish_ok  = 1'b0;
    finish_tmo = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
          if (i_req && d_req)
            winner = (DATA_PRIORITY != 0) ? PORT_D : ~last_grant_q;
          else
            winner = d_req ? PORT_D : PORT_I;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          finish_ok = 1'b1;
          state_d   = RESP;
        end else if (tmo_hit) begin
          finish_tmo = 1'b1;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign resp_data = finish_ok ? mem_rdata : '0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_D;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      tmo_cnt      <= '0;
      err_q        <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q      <= winner;
        last_grant_q <= winner;
        addr_q       <= (winner == PORT_D) ? d_addr : i_addr;
        we_q         <= (winner == PORT_D) && d_we;
        wdata_q      <= ((winner == PORT_D) && d_we) ? d_wdata : '0;
        mem_read     <= !((winner == PORT_D) && d_we);
        mem_write    <= (winner == PORT_D) && d_we;
        tmo_cnt      <= '0;
        err_q        <= 1'b0;
      end
      if (state_q == ACCESS) begin
        if (finish_ok || finish_tmo) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          tmo_cnt   <= '0;
          err_q     <= finish_tmo;
          if (owner_q == PORT_D)
            d_rdata_q <= resp_data;
          else
            i_rdata_q <= resp_data;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

  // done/err decode straight from registered state, so they are glitch-free pulses
  assign i_done    = (state_q == RESP) && (owner_q == PORT_I);
  assign d_done    = (state_q == RESP) && (owner_q == PORT_D);
  assign i_err     = i_done && err_q;
  assign d_err     = d_done && err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a memory responder with programmable wait
// states, per-port request tasks and a scoreboard of expected done and bus transactions.
module tb_mem_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_done, i_err, d_done, d_err;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write, busy;
  logic          mem_ready = 1'b0;
  logic [1:0]    fsm_state;

  int tests = 0;
  int fails = 0;
  int mem_waits = 0;
  int acc_cyc = 0;

  logic [34:0] exp_q[$];   // {check_data, port, err, rdata}
  logic [64:0] acc_q[$];   // {we, addr, wdata}
  logic [34:0] exp_done;
  logic [64:0] exp_acc;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .DATA_PRIORITY(0)
  ) dut (
    .clk(clk), .n_reset(n_reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .fsm_state(fsm_state)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0002_0000) return 32'hE3A0_1005;
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: mem_ready rises after mem_waits strobe cycles
  always @(posedge clk) begin
    #1;
    if (mem_read || mem_write) begin
      mem_ready = (acc_cyc == mem_waits);
      acc_cyc++;
    end else begin
      mem_ready = 1'b0;
      acc_cyc = 0;
    end
  end

  // Scoreboard: bus transactions at mem_ready, responses at done
  always @(negedge clk) begin
    if (n_reset) begin
      if (mem_read || mem_write)
        check("rw_excl", 64'(mem_read & mem_write), 64'(0));
      if (mem_ready && (mem_read || mem_write)) begin
        if (acc_q.size() == 0) check("acc_unexpected", 64'(1), 64'(0));
        else begin
          exp_acc = acc_q.pop_front();
          check("acc_we", 64'(mem_write), 64'(exp_acc[64]));
          check("acc_addr", 64'(mem_addr), 64'(exp_acc[63:32]));
          if (exp_acc[64]) check("acc_wdata", 64'(mem_wdata), 64'(exp_acc[31:0]));
        end
      end
      if (i_done || d_done) begin
        check("one_done", 64'(i_done & d_done), 64'(0));
        if (exp_q.size() == 0) check("done_unexpected", 64'(1), 64'(0));
        else begin
          exp_done = exp_q.pop_front();
          check("done_port", 64'(d_done), 64'(exp_done[33]));
          check("done_err", 64'(d_done ? d_err : i_err), 64'(exp_done[32]));
          if (exp_done[34])
            check("done_data", 64'(d_done ? d_rdata : i_rdata), 64'(exp_done[31:0]));
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit tmo);
    exp_q.push_back({~we, port, tmo, tmo ? 32'h0 : mem_model(addr)});
    if (!tmo) acc_q.push_back({we, addr, we ? wdata : 32'h0});
  endtask

  task automatic run_access(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits, input bit drop_early);
    int lat, rd_cyc, wr_cyc, extra, exp_strb;
    bit tmo, got;
    tmo = (waits >= TMO);
    lat = 0; rd_cyc = 0; wr_cyc = 0; got = 0; extra = 0;
    @(negedge clk);
    mem_waits = waits;
    push_exp(port, we, addr, wdata, tmo);
    if (port == 1'b0) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
    end
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (mem_read) rd_cyc++;
      if (mem_write) wr_cyc++;
      if (mem_read || mem_write) begin
        check("addr_hold", 64'(mem_addr), 64'(addr));
        if (we) check("wdata_hold", 64'(mem_wdata), 64'(wdata));
      end
      if ((port == 1'b0 && i_done) || (port == 1'b1 && d_done)) got = 1;
      if (drop_early && lat == 1) begin
        i_req = 1'b0; d_req = 1'b0;
        i_addr = ~addr; d_addr = ~addr; d_wdata = ~wdata; d_we = ~we;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    exp_strb = tmo ? TMO : waits + 1;
    check("done_seen", 64'(got), 64'(1));
    check("latency", 64'(lat), 64'(tmo ? 1 + TMO : 2 + waits));
    check("rd_cycles", 64'(rd_cyc), 64'(we ? 0 : exp_strb));
    check("wr_cycles", 64'(wr_cyc), 64'(we ? exp_strb : 0));
    if (drop_early) begin
      repeat (4) begin
        @(negedge clk);
        if (i_done || d_done) extra++;
      end
      check("single_done", 64'(extra), 64'(0));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    n_reset = 1'b0;
    #3;
    acc_cyc = 0;
    n_reset = 1'b1;
  endtask

  task automatic reset_mid_access();
    int lat;
    bit got;
    lat = 0; got = 0;
    @(negedge clk);
    mem_waits = 6;
    i_req = 1'b1; i_addr = 32'h0000_4000;
    @(negedge clk);
    @(negedge clk);
    check("busy_mid", 64'(busy), 64'(1));
    check("strobe_mid", 64'(mem_read), 64'(1));
    #2 n_reset = 1'b0;
    #1;
    check("rst_read", 64'(mem_read), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(0));
    @(negedge clk);
    check("rst_no_done", 64'(i_done | d_done), 64'(0));
    mem_waits = 1;
    acc_cyc = 0;
    push_exp(1'b0, 1'b0, 32'h0000_4000, 32'h0, 1'b0);
    n_reset = 1'b1;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (i_done) got = 1;
    end
    i_req = 1'b0;
    check("reserve_seen", 64'(got), 64'(1));
    check("reserve_lat", 64'(lat), 64'(3));
  endtask

  task automatic contention();
    int n, lat;
    n = 0; lat = 0;
    pulse_reset();
    @(negedge clk);
    mem_waits = 0;
    // last_grant is D after reset, so I is served first, then strictly alternating
    for (int k = 0; k < 4; k++)
      push_exp(logic'(k % 2), 1'b0, (k % 2) ? 32'h0000_0400 : 32'h0000_0800, 32'h0, 1'b0);
    i_addr = 32'h0000_0800; d_addr = 32'h0000_0400; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    while (n < 4 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (i_done || d_done) n++;
    end
    i_req = 1'b0; d_req = 1'b0;
    check("contend_dones", 64'(n), 64'(4));
    check("contend_cycles", 64'(lat), 64'(11));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        p, w;
    logic [31:0] a, wd;
    #12;
    check("reset_outs", 64'({mem_read, mem_write, busy, i_done, d_done, i_err, d_err}), 64'(0));
    check("reset_addr", 64'(mem_addr), 64'(0));
    check("reset_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    check("reset_state", 64'(fsm_state), 64'(0));
    @(negedge clk);
    n_reset = 1'b1;

    run_access(1'b0, 1'b0, 32'h0002_0000, 32'h0, 0, 1'b0);
    run_access(1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_BABE, 3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      p  = logic'($urandom_range(0, 1));
      w  = p ? logic'($urandom_range(0, 1)) : 1'b0;
      a  = $urandom & 32'hFFFF_FFFC;
      wd = $urandom;
      run_access(p, w, a, wd, $urandom_range(0, 4), 1'b0);
    end

    run_access(1'b0, 1'b0, 32'h0000_8000, 32'h0, 40, 1'b0);
    run_access(1'b1, 1'b0, 32'h0000_8004, 32'h0, 0, 1'b0);

    run_access(1'b0, 1'b0, 32'h0000_3000, 32'h0, 2, 1'b1);

    reset_mid_access();
    contention();

    repeat (5) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("acc_q_empty", 64'(acc_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
